// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller.
//   SUBSLOTS  : number of PWM subslots in each digit slot
//   SEG_BLANK : led_cx value for a dark digit (active-low, all segments off)
//   SEG_TABLE : hex nibble to active-low segment pattern, bits [6:0] = g..a
package seg7_pkg;

  localparam int SUBSLOTS = 16;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0011000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b0100111,  // c
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit decoder.
//   nibble : hex value to show
//   dp     : 1 lights the decimal point
//   cx     : active-low segments, bit7 = dp, bits[6:0] = g..a
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] cx
);

  // Table lookup; the decimal point is active-low like the segments.
  always_comb begin
    cx = {~dp, SEG_TABLE[nibble]};
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display scanner with PWM brightness, blink,
// leading-zero blanking and tear-free (frame-aligned) data updates.
//   clk, rst    : clock, asynchronous active-high reset
//   data        : hex nibbles, digit 0 in bits [3:0]
//   data_en     : one-cycle load strobe for data / dp_mask / blink_mask
//   dp_mask     : 1 lights the decimal point of that digit
//   blink_mask  : 1 makes that digit blink
//   lzb         : leading-zero blanking enable (live)
//   bright      : PWM duty, digit on for subslots 0..bright (live)
//   led_en      : active-low digit enables, at most one low
//   led_cx      : active-low segments, bit7 = dp, bits[6:0] = g..a
//   frame_start : one-cycle pulse when the digit 0 slot begins
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_CYCLES  = 200000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    data_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lzb,
  input  logic [3:0]              bright,
  output logic [NUM_DIGITS-1:0]   led_en,
  output logic [7:0]              led_cx,
  output logic                    frame_start
);

  localparam int SUB_CYCLES = SCAN_CYCLES / SUBSLOTS;
  localparam int SUB_W      = (SUB_CYCLES > 1)   ? $clog2(SUB_CYCLES)   : 1;
  localparam int IDX_W      = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
  localparam int FR_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // The slot counter is kept as (subslot, cycle-within-subslot) so the
  // PWM comparison needs no divider.
  logic [SUB_W-1:0]        sub_cyc_r;
  logic [3:0]              subslot_r;
  logic [IDX_W-1:0]        idx_r;
  logic [FR_W-1:0]         frame_cnt_r;
  logic                    phase_r;

  logic [4*NUM_DIGITS-1:0] pend_data_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r;
  logic [NUM_DIGITS-1:0]   pend_blink_r;
  logic [4*NUM_DIGITS-1:0] disp_data_r;
  logic [NUM_DIGITS-1:0]   disp_dp_r;
  logic [NUM_DIGITS-1:0]   disp_blink_r;

  logic                    sub_wrap_s;
  logic                    slot_wrap_s;
  logic                    commit_s;
  logic                    frame_begin_s;
  logic [3:0]              cur_nib_s;
  logic                    cur_dp_s;
  logic                    seen_s;
  logic                    lead_zero_s;
  logic                    blank_s;
  logic [NUM_DIGITS-1:0]   en_onehot_s;
  logic [7:0]              dec_cx_s;

  // Wrap conditions of the scan counters; commit happens as the index wraps to 0.
  always_comb begin
    sub_wrap_s    = (sub_cyc_r == SUB_W'(SUB_CYCLES - 1));
    slot_wrap_s   = sub_wrap_s && (subslot_r == 4'd15);
    commit_s      = slot_wrap_s && (idx_r == IDX_W'(NUM_DIGITS - 1));
    frame_begin_s = (sub_cyc_r == {SUB_W{1'b0}}) && (subslot_r == 4'd0) &&
                    (idx_r == {IDX_W{1'b0}});
  end

  // Scan counters, digit index and blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_cyc_r   <= {SUB_W{1'b0}};
      subslot_r   <= 4'd0;
      idx_r       <= {IDX_W{1'b0}};
      frame_cnt_r <= {FR_W{1'b0}};
      phase_r     <= 1'b0;
    end else begin
      if (sub_wrap_s) begin
        sub_cyc_r <= {SUB_W{1'b0}};
        subslot_r <= subslot_r + 4'd1;
      end else begin
        sub_cyc_r <= sub_cyc_r + {{(SUB_W-1){1'b0}}, 1'b1};
      end
      if (commit_s) begin
        idx_r <= {IDX_W{1'b0}};
      end else if (slot_wrap_s) begin
        idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      if (commit_s) begin
        if (frame_cnt_r == FR_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_r <= {FR_W{1'b0}};
          phase_r     <= ~phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + {{(FR_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Pending register: the last strobe in a frame wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data_r  <= {(4*NUM_DIGITS){1'b0}};
      pend_dp_r    <= {NUM_DIGITS{1'b0}};
      pend_blink_r <= {NUM_DIGITS{1'b0}};
    end else if (data_en) begin
      pend_data_r  <= data;
      pend_dp_r    <= dp_mask;
      pend_blink_r <= blink_mask;
    end
  end

  // Display register, updated only between frames; a strobe on the commit
  // cycle bypasses the pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_data_r  <= {(4*NUM_DIGITS){1'b0}};
      disp_dp_r    <= {NUM_DIGITS{1'b0}};
      disp_blink_r <= {NUM_DIGITS{1'b0}};
    end else if (commit_s) begin
      if (data_en) begin
        disp_data_r  <= data;
        disp_dp_r    <= dp_mask;
        disp_blink_r <= blink_mask;
      end else begin
        disp_data_r  <= pend_data_r;
        disp_dp_r    <= pend_dp_r;
        disp_blink_r <= pend_blink_r;
      end
    end
  end

  // Current digit, leading-zero detection and the overall blank decision.
  // A digit is "significant" once any digit at or above it is non-zero or
  // has its decimal point lit; only non-significant digits above 0 blank.
  always_comb begin
    cur_nib_s   = disp_data_r[{idx_r, 2'b00} +: 4];
    cur_dp_s    = disp_dp_r[idx_r];
    seen_s      = 1'b0;
    lead_zero_s = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen_s = seen_s | (disp_data_r[i*4 +: 4] != 4'd0) | disp_dp_r[i];
      if (i == int'(idx_r)) begin
        lead_zero_s = ~seen_s;
      end else begin
        lead_zero_s = lead_zero_s;
      end
    end
    blank_s = (subslot_r > bright) ||
              (phase_r && disp_blink_r[idx_r]) ||
              (lzb && lead_zero_s && (idx_r != {IDX_W{1'b0}}));
    en_onehot_s        = {NUM_DIGITS{1'b1}};
    en_onehot_s[idx_r] = 1'b0;
  end

  seg7_hex_decoder u_dec (
    .nibble (cur_nib_s),
    .dp     (cur_dp_s),
    .cx     (dec_cx_s)
  );

  // Registered outputs, one cycle behind the counter state that selects them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_en      <= {NUM_DIGITS{1'b1}};
      led_cx      <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_begin_s;
      if (blank_s) begin
        led_en <= {NUM_DIGITS{1'b1}};
        led_cx <= SEG_BLANK;
      end else begin
        led_en <= en_onehot_s;
        led_cx <= dec_cx_s;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int SC    = 32;
  localparam int BF    = 2;
  localparam int FRAME = ND * SC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   data = 16'h0000;
  logic          data_en = 1'b0;
  logic [3:0]    dp_mask = 4'h0;
  logic [3:0]    blink_mask = 4'h0;
  logic          lzb = 1'b0;
  logic [3:0]    bright = 4'hF;
  logic [3:0]    led_en;
  logic [7:0]    led_cx;
  logic          frame_start;

  int tick;
  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_CYCLES  (SC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .data_en     (data_en),
    .dp_mask     (dp_mask),
    .blink_mask  (blink_mask),
    .lzb         (lzb),
    .bright      (bright),
    .led_en      (led_en),
    .led_cx      (led_cx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; outputs seen after edge k show
  // counter state k-1 (cycle within frame = (k-1) % FRAME).
  always @(posedge clk or posedge rst) begin
    if (rst) tick <= 0;
    else     tick <= tick + 1;
  end

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blink;
    logic        lzb;
    logic [3:0]  bright;
    int          frame;
    int          digit;
    int          off;
    logic [3:0]  exp_en;
    logic [7:0]  exp_cx;
  } vec_t;

  vec_t vecs [29];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_tick(input int t);
    int guard = 0;
    while (tick != t && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (tick != t) begin
      errors++;
      $display("FAIL wait_tick: got tick %0d, expected %0d", tick, t);
    end
  endtask

  task automatic do_reset(input logic lz, input logic [3:0] br);
    data_en = 1'b0;
    lzb     = lz;
    bright  = br;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    data       = d;
    dp_mask    = dp;
    blink_mask = bl;
    data_en    = 1'b1;
    @(negedge clk);
    data_en    = 1'b0;
  endtask

  initial begin
    //           data     dp    blink lzb   br     fr dg off  en      cx
    vecs[0]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 0, 0, 5,  4'b1110, 8'hC0};
    vecs[1]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 0, 3, 31, 4'b0111, 8'hC0};
    vecs[2]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 1, 0, 0,  4'b1110, 8'h99};
    vecs[3]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 1, 3, 0,  4'b0111, 8'hF9};
    vecs[4]  = '{16'h0020, 4'h0, 4'h0, 1'b1, 4'hF, 1, 3, 4,  4'b1111, 8'hFF};
    vecs[5]  = '{16'h0020, 4'h0, 4'h0, 1'b1, 4'hF, 1, 2, 4,  4'b1111, 8'hFF};
    vecs[6]  = '{16'h0020, 4'h0, 4'h0, 1'b1, 4'hF, 1, 1, 4,  4'b1101, 8'hA4};
    vecs[7]  = '{16'h0020, 4'h0, 4'h0, 1'b1, 4'hF, 1, 0, 4,  4'b1110, 8'hC0};
    vecs[8]  = '{16'h0020, 4'h4, 4'h0, 1'b1, 4'hF, 1, 2, 4,  4'b1011, 8'h40};
    vecs[9]  = '{16'h0020, 4'h0, 4'h0, 1'b0, 4'hF, 1, 3, 4,  4'b0111, 8'hC0};
    vecs[10] = '{16'hABCD, 4'h0, 4'h0, 1'b0, 4'h3, 1, 1, 7,  4'b1101, 8'hA7};
    vecs[11] = '{16'hABCD, 4'h0, 4'h0, 1'b0, 4'h3, 1, 1, 8,  4'b1111, 8'hFF};
    vecs[12] = '{16'hABCD, 4'h0, 4'h0, 1'b0, 4'h3, 1, 1, 31, 4'b1111, 8'hFF};
    vecs[13] = '{16'hABCD, 4'h0, 4'h0, 1'b0, 4'h0, 1, 1, 1,  4'b1101, 8'hA7};
    vecs[14] = '{16'hABCD, 4'h0, 4'h0, 1'b0, 4'h0, 1, 1, 2,  4'b1111, 8'hFF};
    vecs[15] = '{16'h5E6F, 4'h0, 4'h0, 1'b0, 4'hF, 1, 2, 31, 4'b1011, 8'h86};
    vecs[16] = '{16'h5E6F, 4'h0, 4'h0, 1'b0, 4'hF, 1, 0, 0,  4'b1110, 8'h8E};
    vecs[17] = '{16'h5E6F, 4'h0, 4'h0, 1'b0, 4'hF, 1, 3, 0,  4'b0111, 8'h92};
    vecs[18] = '{16'h5E6F, 4'h0, 4'h0, 1'b0, 4'hF, 1, 1, 0,  4'b1101, 8'h82};
    vecs[19] = '{16'h0008, 4'h1, 4'h0, 1'b0, 4'hF, 1, 0, 0,  4'b1110, 8'h00};
    vecs[20] = '{16'h7890, 4'h0, 4'h1, 1'b0, 4'hF, 1, 0, 0,  4'b1110, 8'hC0};
    vecs[21] = '{16'h7890, 4'h0, 4'h1, 1'b0, 4'hF, 2, 0, 0,  4'b1111, 8'hFF};
    vecs[22] = '{16'h7890, 4'h0, 4'h1, 1'b0, 4'hF, 3, 0, 10, 4'b1111, 8'hFF};
    vecs[23] = '{16'h7890, 4'h0, 4'h1, 1'b0, 4'hF, 4, 0, 0,  4'b1110, 8'hC0};
    vecs[24] = '{16'h7890, 4'h0, 4'h1, 1'b0, 4'hF, 2, 1, 0,  4'b1101, 8'h98};
    vecs[25] = '{16'h7890, 4'h0, 4'h1, 1'b0, 4'hF, 3, 3, 0,  4'b0111, 8'hF8};
    vecs[26] = '{16'hABCD, 4'h0, 4'h0, 1'b0, 4'hF, 1, 3, 0,  4'b0111, 8'h88};
    vecs[27] = '{16'hABCD, 4'h0, 4'h0, 1'b0, 4'hF, 1, 2, 0,  4'b1011, 8'h83};
    vecs[28] = '{16'hABCD, 4'h0, 4'h0, 1'b0, 4'hF, 1, 0, 0,  4'b1110, 8'hA1};

    // Reset values and scan start timing.
    repeat (2) @(negedge clk);
    check("rst_en", {4'h0, led_en}, 8'h0F);
    check("rst_cx", led_cx, 8'hFF);
    check("rst_fs", {7'h0, frame_start}, 8'h00);
    rst = 1'b0;
    wait_tick(1);
    check("start_en", {4'h0, led_en}, 8'h0E);
    check("start_cx", led_cx, 8'hC0);
    check("start_fs", {7'h0, frame_start}, 8'h01);
    wait_tick(2);
    check("fs_pulse_end", {7'h0, frame_start}, 8'h00);
    wait_tick(33);
    check("digit1_en", {4'h0, led_en}, 8'h0D);
    wait_tick(129);
    check("wrap_en", {4'h0, led_en}, 8'h0E);
    check("wrap_fs", {7'h0, frame_start}, 8'h01);

    // Table of single-point vectors, each from a fresh reset.
    for (int i = 0; i < 29; i++) begin
      do_reset(vecs[i].lzb, vecs[i].bright);
      load(vecs[i].data, vecs[i].dp, vecs[i].blink);
      wait_tick(vecs[i].frame * FRAME + vecs[i].digit * SC + vecs[i].off + 1);
      check($sformatf("vec%0d_en", i), {4'h0, led_en}, {4'h0, vecs[i].exp_en});
      check($sformatf("vec%0d_cx", i), led_cx, vecs[i].exp_cx);
    end

    // Strobe on the commit cycle overrides an earlier pending load.
    do_reset(1'b0, 4'hF);
    wait_tick(50);
    load(16'h0001, 4'h0, 4'h0);
    wait_tick(127);
    load(16'h0003, 4'h0, 4'h0);
    wait_tick(129);
    check("commit_direct_cx", led_cx, 8'hB0);
    check("commit_direct_en", {4'h0, led_en}, 8'h0E);

    // Several strobes in one frame: the last one is committed.
    do_reset(1'b0, 4'hF);
    wait_tick(10);
    load(16'h0001, 4'h0, 4'h0);
    wait_tick(60);
    load(16'h0002, 4'h0, 4'h0);
    wait_tick(129);
    check("last_strobe_cx", led_cx, 8'hA4);

    // Reset mid-frame discards the uncommitted load.
    do_reset(1'b0, 4'hF);
    wait_tick(10);
    load(16'h0009, 4'h0, 4'h0);
    wait_tick(20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_tick(129);
    check("rst_discard_cx", led_cx, 8'hC0);
    wait_tick(257);
    check("rst_discard_cx2", led_cx, 8'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, giving the number of scanned hex digits (legal range 1..8).
REQ-002 The block SHALL have parameter SCAN_CYCLES, default 200000, giving clk cycles per digit slot (2 ms at 100 MHz); it must be a multiple of 16 and at least 16.
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 64, giving full scan frames per blink half-period (at least 1).
REQ-004 The clock and reset SHALL be: reset rst, asynchronous, active-high; clock clk.
REQ-005 The block SHALL have port data, input, 4*NUM_DIGITS bits: hex nibbles, with digit 0 in bits [3:0].
REQ-006 The block SHALL have port data_en, input, 1 bit: single-cycle load strobe for data, dp_mask and blink_mask.
REQ-007 The block SHALL have port dp_mask, input, NUM_DIGITS bits: 1 lights the decimal point of that digit.
REQ-008 The block SHALL have port blink_mask, input, NUM_DIGITS bits: 1 makes that digit blink.
REQ-009 The block SHALL have port lzb, input, 1 bit: leading-zero blanking enable, sampled live.
REQ-010 The block SHALL have port bright, input, 4 bits: PWM duty, with on-time equal to (bright+1)/16 of each slot, sampled live.
REQ-011 The block SHALL have port led_en, output, NUM_DIGITS bits: active-low digit enable, at most one bit low.
REQ-012 The block SHALL have port led_cx, output, 8 bits, active-low segments: bit7 = dp, bits[6:0] = g..a.
REQ-013 The block SHALL have port frame_start, output, 1 bit: a one-cycle pulse when digit 0 slot begins.

Function
REQ-014 Slot counter SHALL count 0..SCAN_CYCLES-1 and wrap; each wrap SHALL advance the digit index 0,1,..,NUM_DIGITS-1,0.
REQ-015 Each slot SHALL be split into 16 subslots of SCAN_CYCLES/16 cycles; the digit SHALL be enabled in subslots 0..bright and blanked otherwise.
REQ-016 data_en SHALL capture data, dp_mask and blink_mask into a pending register; contents SHALL be copied to the display register only on the cycle the index wraps to 0 (tear-free).
REQ-017 If data_en coincides with the commit cycle, the values on the inputs that cycle SHALL be committed directly.
REQ-018 Multiple data_en strobes within one frame SHALL leave only the last value to be committed.
REQ-019 With lzb=1, zero digits above the most significant non-zero digit SHALL be blanked; digit 0 SHALL never be blanked by lzb; a digit with its dp_mask bit set SHALL not be blanked by lzb.
REQ-020 A blink phase bit SHALL toggle every BLINK_FRAMES frames; while phase=1, digits with blink_mask set SHALL be blanked.
REQ-021 A blanked digit SHALL drive its led_en bit to 1 and led_cx to 8'hFF.
REQ-022 Segment encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000110, F=0001110; dp SHALL be 0 when lit.
REQ-023 led_en and led_cx SHALL be registered and change in the same cycle, one clk after the counter state that selects them.

Reset
REQ-024 On rst, led_en SHALL go to all ones and led_cx to 8'hFF.
REQ-025 On rst, frame_start SHALL go to 0, all counters and the blink phase to 0, and the pending and display registers to 0.
REQ-026 The first frame_start SHALL occur on the first cycle after rst deasserts, and scanning SHALL begin with digit 0.
REQ-027 rst mid-frame SHALL discard any pending uncommitted load.

Structure
REQ-028 Package seg7_pkg SHALL hold the 16-entry segment table, the blank constant 8'hFF and the subslot count 16.
REQ-029 Sub-module seg7_hex_decoder SHALL be a combinational nibble+dp to led_cx decoder, instantiated once.

Verification (NUM_DIGITS=4, SCAN_CYCLES=32, BLINK_FRAMES=2)
REQ-030 Reset, then release: led_en=1111/led_cx=FF while rst is asserted; led_en=1110 one cycle after release, 1101 after 32 cycles, and 1110 again after 128 cycles.
REQ-031 data=0x1234 with data_en mid-frame: displayed digits SHALL be unchanged until the next frame_start, after which the digit 0 slot SHALL show led_cx=8'b10011001 (4).
REQ-032 lzb=1, data=0x0020: digits 3 and 2 SHALL keep led_en high; digit 1 SHALL show 2 and digit 0 SHALL show 0.
REQ-033 bright=3: the active digit SHALL be low for 8 cycles and high for 24 cycles per slot; with bright=15 it SHALL be low for all 32 cycles.
REQ-034 blink_mask=0001: digit 0 SHALL be dark in frames 2-3, lit in frames 4-5, and so on; other digits SHALL be always lit.
REQ-035 data_en coinciding with the index wrap to 0: the new value SHALL be shown in that same frame.
